// File: rtl/regfile_sb_if.sv
// Register-file bus: decode-side reads/allocation, write-back ports,
// flush, debug read and the outstanding-load count.
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_busy_a;
  logic              rd_busy_b;
  logic              wa_en;
  logic [ADDR_W-1:0] wa_addr;
  logic [DATA_W-1:0] wa_data;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic              flush;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [ADDR_W:0]   busy_count;

  // Pipeline side: drives addresses, write-back and allocation.
  modport master (
    output rd_addr_a, rd_addr_b, wa_en, wa_addr, wa_data,
           wb_en, wb_addr, wb_data, alloc_en, alloc_addr, flush, dbg_addr,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, dbg_data, busy_count
  );

  // Register-file side.
  modport slave (
    input  rd_addr_a, rd_addr_b, wa_en, wa_addr, wa_data,
           wb_en, wb_addr, wb_data, alloc_en, alloc_addr, flush, dbg_addr,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, dbg_data, busy_count
  );
endinterface

// File: rtl/regfile_sb.sv
// Dual-write register file with same-cycle bypass, a per-register
// pending-load scoreboard, an outstanding-load counter and flush.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input logic         clk,
  input logic         startin_n,
  regfile_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [ADDR_W:0]   r_count;

  logic              w_wa_ok;
  logic              w_wb_ok;
  logic              w_alloc_ok;
  logic              w_inc;
  logic              w_dec;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [ADDR_W:0]   w_count_nxt;

  // Bypass priority: port A (younger ALU result) over port B (load), then storage.
  function automatic logic [DATA_W-1:0] f_read(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wa_en,
    input logic [ADDR_W-1:0] wa_addr,
    input logic [DATA_W-1:0] wa_data,
    input logic              wb_en,
    input logic [ADDR_W-1:0] wb_addr,
    input logic [DATA_W-1:0] wb_data
  );
    logic [DATA_W-1:0] res;
    if (ZR && (addr == '0))              res = '0;
    else if (wa_en && (wa_addr == addr)) res = wa_data;
    else if (wb_en && (wb_addr == addr)) res = wb_data;
    else                                 res = stored;
    return res;
  endfunction

  // Busy as seen by a reader: a same-cycle load return clears it unless a
  // same-cycle allocation of that register re-arms it.
  function automatic logic f_busy(
    input logic [ADDR_W-1:0] addr,
    input logic [DEPTH-1:0]  busy,
    input logic              wb_en,
    input logic [ADDR_W-1:0] wb_addr,
    input logic              alloc_en,
    input logic [ADDR_W-1:0] alloc_addr
  );
    return busy[addr] &&
           !(wb_en && (wb_addr == addr) && !(alloc_en && (alloc_addr == addr)));
  endfunction

  // Writes and allocations to the hardwired zero register are dropped.
  assign w_wa_ok    = bus.wa_en    && !(ZR && (bus.wa_addr    == '0));
  assign w_wb_ok    = bus.wb_en    && !(ZR && (bus.wb_addr    == '0));
  assign w_alloc_ok = bus.alloc_en && !(ZR && (bus.alloc_addr == '0));

  // Count moves only on real 0->1 and 1->0 transitions of a busy bit.
  assign w_inc = w_alloc_ok && !r_busy[bus.alloc_addr];
  assign w_dec = bus.wb_en && r_busy[bus.wb_addr] &&
                 !(w_alloc_ok && (bus.alloc_addr == bus.wb_addr));

  // Next scoreboard state: flush, then alloc, then load-return clear.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.wb_en) w_busy_nxt[bus.wb_addr] = 1'b0;
    if (w_alloc_ok) w_busy_nxt[bus.alloc_addr] = 1'b1;
    if (bus.flush) w_busy_nxt = '0;
    if (ZR) w_busy_nxt[0] = 1'b0;
  end

  // Next outstanding count, tracking the popcount without recomputing it.
  always_comb begin
    w_count_nxt = r_count;
    if (bus.flush)
      w_count_nxt = '0;
    else
      w_count_nxt = r_count + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
  end

  // Architectural registers; port A is written last so it wins on a collision.
  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (w_wb_ok) r_regs[bus.wb_addr] <= bus.wb_data;
      if (w_wa_ok) r_regs[bus.wa_addr] <= bus.wa_data;
    end
  end

  // Scoreboard bits and outstanding-load count.
  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      r_busy  <= '0;
      r_count <= '0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_count <= w_count_nxt;
    end
  end

  assign bus.rd_data_a  = f_read(bus.rd_addr_a, r_regs[bus.rd_addr_a],
                                 bus.wa_en, bus.wa_addr, bus.wa_data,
                                 bus.wb_en, bus.wb_addr, bus.wb_data);
  assign bus.rd_data_b  = f_read(bus.rd_addr_b, r_regs[bus.rd_addr_b],
                                 bus.wa_en, bus.wa_addr, bus.wa_data,
                                 bus.wb_en, bus.wb_addr, bus.wb_data);
  assign bus.rd_busy_a  = f_busy(bus.rd_addr_a, r_busy, bus.wb_en, bus.wb_addr,
                                 bus.alloc_en, bus.alloc_addr);
  assign bus.rd_busy_b  = f_busy(bus.rd_addr_b, r_busy, bus.wb_en, bus.wb_addr,
                                 bus.alloc_en, bus.alloc_addr);
  assign bus.dbg_data   = r_regs[bus.dbg_addr];
  assign bus.busy_count = r_count;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, dual write, zero register,
// scoreboard/count sequencing, flush and asynchronous mid-stream reset.
module tb_regfile_sb;

  logic clk;
  logic startin_n;
  int   n_tests;
  int   n_fail;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk       (clk),
    .startin_n (startin_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wa_en = 1'b0; bus.wb_en = 1'b0; bus.alloc_en = 1'b0; bus.flush = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    startin_n = 1'b0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0; bus.dbg_addr = '0;
    bus.wa_en = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.alloc_en = 1'b0; bus.alloc_addr = '0; bus.flush = 1'b0;

    // 1. Reset held, then released
    #3;
    chk("rst_held_count", 32'(bus.busy_count), 32'd0);
    chk("rst_held_busy_a", 32'(bus.rd_busy_a), 32'd0);
    chk("rst_held_rd_a", bus.rd_data_a, 32'd0);
    tick();
    startin_n = 1'b1;
    tick();
    for (int i = 0; i < 32; i++) begin
      bus.dbg_addr = 5'(i);
      #1;
      chk($sformatf("rst_dbg%0d", i), bus.dbg_data, 32'd0);
    end
    chk("rst_count", 32'(bus.busy_count), 32'd0);
    chk("rst_busy_a", 32'(bus.rd_busy_a), 32'd0);

    // 2. Same-cycle bypass from port A; storage updates one edge later
    tick();
    bus.wa_en = 1'b1; bus.wa_addr = 5'd5; bus.wa_data = 32'hDEAD_BEEF;
    bus.rd_addr_a = 5'd5; bus.dbg_addr = 5'd5;
    #1;
    chk("byp_a_same", bus.rd_data_a, 32'hDEAD_BEEF);
    chk("byp_dbg_before", bus.dbg_data, 32'd0);
    tick();
    idle();
    #1;
    chk("byp_dbg_after", bus.dbg_data, 32'hDEAD_BEEF);
    chk("byp_rd_after", bus.rd_data_a, 32'hDEAD_BEEF);

    // 3. Dual write, same address: port A wins
    bus.wa_en = 1'b1; bus.wa_addr = 5'd7; bus.wa_data = 32'h1111;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'h2222;
    bus.rd_addr_b = 5'd7; bus.dbg_addr = 5'd7;
    #1;
    chk("dual_byp_b", bus.rd_data_b, 32'h1111);
    tick();
    idle();
    #1;
    chk("dual_reg7", bus.dbg_data, 32'h1111);

    // Port B only: load bypass and write
    bus.wb_en = 1'b1; bus.wb_addr = 5'd8; bus.wb_data = 32'h2222;
    bus.rd_addr_b = 5'd8; bus.dbg_addr = 5'd8;
    #1;
    chk("wb_byp_b", bus.rd_data_b, 32'h2222);
    tick();
    idle();
    #1;
    chk("wb_reg8", bus.dbg_data, 32'h2222);

    // 4. Register 0 is hardwired to zero, including bypass
    bus.wa_en = 1'b1; bus.wa_addr = 5'd0; bus.wa_data = 32'hFFFF_FFFF;
    bus.rd_addr_a = 5'd0; bus.dbg_addr = 5'd0;
    #1;
    chk("r0_byp", bus.rd_data_a, 32'd0);
    tick();
    idle();
    #1;
    chk("r0_after", bus.rd_data_a, 32'd0);
    chk("r0_dbg", bus.dbg_data, 32'd0);

    // 5. Scoreboard: alloc 3, then alloc 9
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3; bus.rd_addr_a = 5'd3;
    #1;
    chk("alloc3_not_yet", 32'(bus.rd_busy_a), 32'd0);
    tick();
    bus.alloc_addr = 5'd9; bus.rd_addr_b = 5'd9;
    #1;
    chk("alloc3_busy", 32'(bus.rd_busy_a), 32'd1);
    chk("alloc3_count", 32'(bus.busy_count), 32'd1);
    tick();
    idle();
    #1;
    chk("alloc9_busy", 32'(bus.rd_busy_b), 32'd1);
    chk("alloc_count2", 32'(bus.busy_count), 32'd2);

    // Load return to 3 with re-alloc of 3: stays busy, data written
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h42;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3; bus.dbg_addr = 5'd3;
    #1;
    chk("wb3_alloc3_busy", 32'(bus.rd_busy_a), 32'd1);
    chk("wb3_byp", bus.rd_data_a, 32'h42);
    tick();
    idle();
    #1;
    chk("wb3_busy_after", 32'(bus.rd_busy_a), 32'd1);
    chk("wb3_reg", bus.dbg_data, 32'h42);
    chk("wb3_count", 32'(bus.busy_count), 32'd2);

    // Load return to 9 alone: clear visible same cycle, count drops
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
    #1;
    chk("wb9_clear_same", 32'(bus.rd_busy_b), 32'd0);
    tick();
    idle();
    #1;
    chk("wb9_count", 32'(bus.busy_count), 32'd1);
    chk("wb9_busy_after", 32'(bus.rd_busy_b), 32'd0);
    chk("wb9_keep3", 32'(bus.rd_busy_a), 32'd1);

    // Alloc of register 0 is ignored
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd0;
    tick();
    idle();
    bus.rd_addr_b = 5'd0;
    #1;
    chk("alloc0_count", 32'(bus.busy_count), 32'd1);
    chk("alloc0_busy", 32'(bus.rd_busy_b), 32'd0);

    // Alloc 12 and return 3 together on different registers: net zero
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd12;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h43;
    tick();
    idle();
    bus.rd_addr_b = 5'd12;
    #1;
    chk("net0_count", 32'(bus.busy_count), 32'd1);
    chk("net0_busy12", 32'(bus.rd_busy_b), 32'd1);
    chk("net0_busy3", 32'(bus.rd_busy_a), 32'd0);

    // 6. Flush with 3 and 9 busy, alongside alloc 12
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd3;
    tick();
    bus.alloc_addr = 5'd9;
    tick();
    idle();
    #1;
    chk("pre_flush_count", 32'(bus.busy_count), 32'd3);
    bus.flush = 1'b1; bus.alloc_en = 1'b1; bus.alloc_addr = 5'd12;
    tick();
    idle();
    bus.rd_addr_b = 5'd9;
    #1;
    chk("flush_count", 32'(bus.busy_count), 32'd0);
    chk("flush_busy3", 32'(bus.rd_busy_a), 32'd0);
    chk("flush_busy9", 32'(bus.rd_busy_b), 32'd0);
    bus.rd_addr_b = 5'd12;
    #1;
    chk("flush_busy12", 32'(bus.rd_busy_b), 32'd0);

    // Asynchronous reset mid-stream, between clock edges
    tick();
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd5;
    tick();
    idle();
    bus.rd_addr_a = 5'd5; bus.dbg_addr = 5'd5;
    #1;
    chk("pre_rst_count", 32'(bus.busy_count), 32'd1);
    chk("pre_rst_reg5", bus.dbg_data, 32'hDEAD_BEEF);
    #1;
    startin_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus.busy_count), 32'd0);
    chk("arst_busy5", 32'(bus.rd_busy_a), 32'd0);
    chk("arst_reg5", bus.dbg_data, 32'd0);
    chk("arst_rd5", bus.rd_data_a, 32'd0);

    // Writes and allocations during held reset are discarded
    bus.wa_en = 1'b1; bus.wa_addr = 5'd6; bus.wa_data = 32'h6666;
    bus.alloc_en = 1'b1; bus.alloc_addr = 5'd6;
    tick();
    idle();
    bus.dbg_addr = 5'd6;
    #1;
    chk("arst_hold_reg6", bus.dbg_data, 32'd0);
    chk("arst_hold_count", 32'(bus.busy_count), 32'd0);
    startin_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-cycle CPU register file.
- Adds:
  - two independent write ports: port A for ALU write-back, port B for load write-back;
  - same-cycle write-to-read bypass;
  - a per-register pending-load scoreboard with an outstanding count;
  - pipeline flush.
- Sits between decode (reads, allocation) and the write-back stages of the pipelined core.
- Keeps the debug read port (dbg_addr/dbg_data).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and never busy

Ports:
- clk  in  1  single clock; all state updates on rising edge
- startin_n  in  1  reset, asynchronous, active-low
- rd_addr_a  in  ADDR_W  read port A address
- rd_addr_b  in  ADDR_W  read port B address
- rd_data_a  out  DATA_W  read port A data (combinational, bypassed)
- rd_data_b  out  DATA_W  read port B data (combinational, bypassed)
- rd_busy_a  out  1  register at rd_addr_a has a load pending
- rd_busy_b  out  1  register at rd_addr_b has a load pending
- wa_en  in  1  write port A enable (ALU)
- wa_addr  in  ADDR_W  write port A address
- wa_data  in  DATA_W  write port A data
- wb_en  in  1  write port B enable (load return); also clears busy
- wb_addr  in  ADDR_W  write port B address
- wb_data  in  DATA_W  write port B data
- alloc_en  in  1  mark alloc_addr busy (load issued)
- alloc_addr  in  ADDR_W  register to mark busy
- flush  in  1  clear all busy bits (pipeline squash)
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data (no bypass, architectural state)
- busy_count  out  ADDR_W+1  number of registers currently busy

Behaviour:
Reset
- startin_n low, asynchronous: all registers = 0, all busy bits = 0, busy_count = 0.
- Consequence: rd_data_* = 0, rd_busy_* = 0, dbg_data = 0 while reset is held.
- Reset asserted mid-operation discards any in-flight writes and allocations that cycle.

Write
- Registered; takes effect at the rising edge.
- Same address on both ports in the same cycle: port A data wins (younger instruction). Port B still clears busy.
- ZERO_REG=1: writes to address 0 are ignored.

Read (combinational)
- rd_data_x = wa_data if wa_en and wa_addr==rd_addr_x.
- Else wb_data if wb_en and wb_addr==rd_addr_x.
- Else the stored register.
- Address 0 with ZERO_REG=1 always returns 0, bypass included.
- dbg_data = stored register only.

Scoreboard
- busy[r] next state, in priority order:
  1. flush: 0 for all r.
  2. alloc_en and alloc_addr==r: 1. Alloc wins over a same-cycle clear of the same r.
  3. wb_en and wb_addr==r: 0.
  4. Otherwise: hold.
- Address 0 is never busy when ZERO_REG=1.
- rd_busy_x = busy[rd_addr_x] and not (wb_en and wb_addr==rd_addr_x and not (alloc_en and alloc_addr==rd_addr_x)).
  - The same-cycle clear is visible; a same-cycle alloc is not visible until the next cycle.
- Port A does not affect busy.

busy_count
- Registered; always equals the popcount of the busy bits.
- Updated incrementally: +1 only when alloc sets a bit that was 0; -1 only when wb clears a bit that was 1 (not overridden by alloc).
- Both events on different registers in the same cycle: net 0.
- flush: 0 next cycle; overrides any alloc that cycle.
- Bounded by 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG=1); no wrap.

Latency
- Write to stored state: 1 cycle.
- Bypass to read: 0 cycles.
- Alloc to rd_busy: 1 cycle.

Test Plan:
1. Reset: hold startin_n=0, then release.
   - Expected: dbg_data=0 for all 32 addresses; busy_count=0; rd_busy_a=0.
2. Bypass, same cycle: wa_en=1, wa_addr=5, wa_data=32'hDEAD_BEEF, rd_addr_a=5.
   - Expected: rd_data_a=DEADBEEF the same cycle; dbg_data(5)=DEADBEEF from the next cycle.
3. Dual write, same address: wa(7,32'h1111) and wb(7,32'h2222) together.
   - Expected: reg7=32'h1111 after the edge.
4. Write to register 0: wa(0,32'hFFFF_FFFF).
   - Expected: rd_data_a at address 0 = 0 the same cycle and afterwards.
5. Scoreboard sequence:
   - Cycle 1: alloc 3; alloc 9.
   - Expected: rd_busy on 3 = 1; busy_count=2.
   - Next cycle: wb(3,32'h42) with alloc 3.
   - Expected: busy[3] stays 1; reg3=32'h42; count=2.
   - Then: wb(9) alone.
   - Expected: rd_busy_b(9)=0 in that cycle; count=1 after.
6. Flush: with regs 3 and 9 busy, assert flush together with alloc 12.
   - Expected: all busy bits 0 and busy_count=0 next cycle.
   - Then assert startin_n=0 mid-stream.
   - Expected: all state cleared immediately, without waiting for a clock edge.
